// File: rtl/scalar_wb_pkg.sv
// Shared types and default widths for the scalar writeback arbiter and its load FIFO.
package scalar_wb_pkg;

   localparam int REG_SIZE_DEF     = 32;
   localparam int REG_QUANTITY_DEF = 4;
   localparam int SEL_BITS_DEF     = 2;
   localparam int LOAD_DEPTH_DEF   = 4;
   localparam int MAX_WAIT_DEF     = 3;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_ALU  = 2'd1,
      GRANT_LOAD = 2'd2
   } wb_grant_t;

   typedef struct packed {
      logic [SEL_BITS_DEF-1:0] rd;
      logic [REG_SIZE_DEF-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous load-result FIFO; exposes per-entry valid/rd so the owner can build a pending mask.
module wb_fifo
   import scalar_wb_pkg::*;
#(
   parameter int RdW   = SEL_BITS_DEF,
   parameter int DataW = REG_SIZE_DEF,
   parameter int Depth = LOAD_DEPTH_DEF,
   localparam int PtrW = $clog2(Depth),
   localparam int CntW = PtrW + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [RdW-1:0]         in_rd_i,
   input  logic [DataW-1:0]       in_data_i,
   output logic [RdW-1:0]         head_rd_o,
   output logic [DataW-1:0]       head_data_o,
   output logic [CntW-1:0]        count_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [Depth-1:0]       entry_valid_o,
   output logic [Depth*RdW-1:0]   entry_rd_o
);

   logic [RdW-1:0]   rd_q   [Depth];
   logic [DataW-1:0] data_q [Depth];
   logic [Depth-1:0] valid_q;
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
      rptr_d  = do_pop  ? rptr_q + PtrW'(1) : rptr_q;
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Push and pop never address the same slot: push needs not-full, pop needs not-empty.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (do_push) begin
            rd_q[wptr_q]    <= in_rd_i;
            data_q[wptr_q]  <= in_data_i;
            valid_q[wptr_q] <= 1'b1;
         end
         if (do_pop) begin
            valid_q[rptr_q] <= 1'b0;
         end
      end
   end

   assign head_rd_o     = rd_q[rptr_q];
   assign head_data_o   = data_q[rptr_q];
   assign count_o       = count_q;
   assign entry_valid_o = valid_q;

   for (genvar i = 0; i < Depth; i++) begin : g_entry_rd
      assign entry_rd_o[i*RdW +: RdW] = rd_q[i];
   end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results into one register-file
// write per cycle, keeping write-after-write order per register and bounding load starvation.
module scalar_wb_arbiter
   import scalar_wb_pkg::*;
#(
   parameter int regSize     = REG_SIZE_DEF,
   parameter int regQuantity = REG_QUANTITY_DEF,
   parameter int selBits     = SEL_BITS_DEF,
   parameter int loadDepth   = LOAD_DEPTH_DEF,
   parameter int maxWait     = MAX_WAIT_DEF,
   localparam int CntW  = $clog2(loadDepth) + 1,
   localparam int WaitW = $clog2(maxWait + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   aluValid,
   output logic                   aluReady,
   input  logic [selBits-1:0]     aluRd,
   input  logic [regSize-1:0]     aluData,
   input  logic                   ldValid,
   output logic                   ldReady,
   input  logic [selBits-1:0]     ldRd,
   input  logic [regSize-1:0]     ldData,
   output logic                   regWrEn,
   output logic [selBits-1:0]     regToWrite,
   output logic [regSize-1:0]     dataIn,
   output logic [regQuantity-1:0] pendingMask,
   output logic [CntW-1:0]        ldCount
);

   wb_grant_t                  grant;
   logic                       fifo_full, fifo_empty;
   logic [selBits-1:0]         head_rd;
   logic [regSize-1:0]         head_data;
   logic [loadDepth-1:0]       entry_valid;
   logic [loadDepth*selBits-1:0] entry_rd;
   logic [regQuantity-1:0]     pending;
   logic                       alu_blocked, starve;
   logic [WaitW-1:0]           wait_cnt_q, wait_cnt_d;
   logic                       reg_wr_en_q, reg_wr_en_d;
   logic [selBits-1:0]         reg_to_write_q, reg_to_write_d;
   logic [regSize-1:0]         data_in_q, data_in_d;

   wb_fifo #(
      .RdW   (selBits),
      .DataW (regSize),
      .Depth (loadDepth)
   ) u_ld_fifo (
      .clk           (clk),
      .reset         (reset),
      .push_i        (ldValid),
      .pop_i         (grant == GRANT_LOAD),
      .in_rd_i       (ldRd),
      .in_data_i     (ldData),
      .head_rd_o     (head_rd),
      .head_data_o   (head_data),
      .count_o       (ldCount),
      .full_o        (fifo_full),
      .empty_o       (fifo_empty),
      .entry_valid_o (entry_valid),
      .entry_rd_o    (entry_rd)
   );

   // Built from registered FIFO state only, so a same-cycle enqueue is not yet visible.
   always_comb begin
      pending = '0;
      for (int i = 0; i < loadDepth; i++) begin
         if (entry_valid[i]) begin
            pending[entry_rd[i*selBits +: selBits]] = 1'b1;
         end
      end
   end

   assign alu_blocked = pending[aluRd];
   assign starve      = (wait_cnt_q == WaitW'(maxWait)) && !fifo_empty;

   always_comb begin
      grant = GRANT_NONE;
      if (!fifo_empty && (starve || !aluValid || alu_blocked)) begin
         grant = GRANT_LOAD;
      end else if (aluValid && !alu_blocked) begin
         grant = GRANT_ALU;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (fifo_empty || grant == GRANT_LOAD) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WaitW'(maxWait)) begin
         wait_cnt_d = wait_cnt_q + WaitW'(1);
      end
   end

   always_comb begin
      reg_wr_en_d    = 1'b0;
      reg_to_write_d = reg_to_write_q;
      data_in_d      = data_in_q;
      case (grant)
         GRANT_ALU: begin
            reg_wr_en_d    = 1'b1;
            reg_to_write_d = aluRd;
            data_in_d      = aluData;
         end
         GRANT_LOAD: begin
            reg_wr_en_d    = 1'b1;
            reg_to_write_d = head_rd;
            data_in_d      = head_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt_q     <= '0;
         reg_wr_en_q    <= 1'b0;
         reg_to_write_q <= '0;
         data_in_q      <= '0;
      end else begin
         wait_cnt_q     <= wait_cnt_d;
         reg_wr_en_q    <= reg_wr_en_d;
         reg_to_write_q <= reg_to_write_d;
         data_in_q      <= data_in_d;
      end
   end

   assign aluReady    = (grant == GRANT_ALU);
   assign ldReady     = ~fifo_full;
   assign pendingMask = pending;
   assign regWrEn     = reg_wr_en_q;
   assign regToWrite  = reg_to_write_q;
   assign dataIn      = data_in_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed scenarios for the writeback arbiter; every register-file write is checked in order
// against an expected queue filled as each grant is anticipated.
module tb_scalar_wb_arbiter;

   localparam int RS = 32;
   localparam int RQ = 4;
   localparam int SB = 2;
   localparam int LD = 4;
   localparam int MW = 3;
   localparam int CW = $clog2(LD) + 1;
   localparam int W  = SB + RS;

   logic          clk;
   logic          reset;
   logic          aluValid, aluReady;
   logic [SB-1:0] aluRd;
   logic [RS-1:0] aluData;
   logic          ldValid, ldReady;
   logic [SB-1:0] ldRd;
   logic [RS-1:0] ldData;
   logic          regWrEn;
   logic [SB-1:0] regToWrite;
   logic [RS-1:0] dataIn;
   logic [RQ-1:0] pendingMask;
   logic [CW-1:0] ldCount;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  got_w, want_w;
   int            checks = 0;
   int            errors = 0;

   scalar_wb_arbiter #(
      .regSize     (RS),
      .regQuantity (RQ),
      .selBits     (SB),
      .loadDepth   (LD),
      .maxWait     (MW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .aluValid    (aluValid),
      .aluReady    (aluReady),
      .aluRd       (aluRd),
      .aluData     (aluData),
      .ldValid     (ldValid),
      .ldReady     (ldReady),
      .ldRd        (ldRd),
      .ldData      (ldData),
      .regWrEn     (regWrEn),
      .regToWrite  (regToWrite),
      .dataIn      (dataIn),
      .pendingMask (pendingMask),
      .ldCount     (ldCount)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard: every write must match the oldest expected entry
   always @(negedge clk) begin
      if (regWrEn === 1'b1) begin
         checks++;
         got_w = {regToWrite, dataIn};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got rd=%0d data=%h, expected no write", regToWrite, dataIn);
         end else begin
            want_w = exp_q.pop_front();
            if (got_w !== want_w) begin
               errors++;
               $display("FAIL write_order got rd=%0d data=%h, expected rd=%0d data=%h",
                        got_w[W-1 -: SB], got_w[RS-1:0], want_w[W-1 -: SB], want_w[RS-1:0]);
            end
         end
      end
   end

   // driver helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      aluValid = 1'b0;
      ldValid  = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      aluValid = 1'b1;
      aluRd    = 2'd3;
      aluData  = 32'h0000_00A5;
      ldValid  = 1'b0;
      ldRd     = '0;
      ldData   = '0;
      step();
      step();
      checks++;
      if ({regWrEn, regToWrite, dataIn} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got en=%b rd=%0d data=%h, expected all zero", regWrEn, regToWrite, dataIn);
      end
      checks++;
      if (pendingMask !== '0 || ldCount !== '0) begin
         errors++;
         $display("FAIL reset_fifo got mask=%b count=%0d, expected 0/0", pendingMask, ldCount);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (aluReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b, expected 1", aluReady);
      end
      exp_q.push_back({2'd3, 32'h0000_00A5});
      step();
      idle();
      checks++;
      if (regWrEn !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_write got en=%b, expected 1", regWrEn);
      end
      step();
   endtask

   task automatic test_alu_only();
      aluValid = 1'b1;
      aluRd    = 2'd2;
      aluData  = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (aluReady !== 1'b1) begin
         errors++;
         $display("FAIL alu_only_ready got %b, expected 1", aluReady);
      end
      exp_q.push_back({2'd2, 32'hDEAD_BEEF});
      step();
      idle();
      checks++;
      if (regWrEn !== 1'b1 || regToWrite !== 2'd2 || dataIn !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL alu_only_write got en=%b rd=%0d data=%h, expected 1/2/deadbeef", regWrEn, regToWrite, dataIn);
      end
      step();
      checks++;
      if (regWrEn !== 1'b0 || regToWrite !== 2'd2 || dataIn !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL none_hold got en=%b rd=%0d data=%h, expected 0/2/deadbeef", regWrEn, regToWrite, dataIn);
      end
   endtask

   task automatic test_waw();
      aluValid = 1'b1;
      aluRd    = 2'd3;
      aluData  = 32'h33;
      ldValid  = 1'b1;
      ldRd     = 2'd1;
      ldData   = 32'h11;
      #1;
      exp_q.push_back({2'd3, 32'h33});
      step();
      ldValid = 1'b0;
      aluRd   = 2'd1;
      aluData = 32'h22;
      #1;
      checks++;
      if (pendingMask !== 4'b0010 || ldCount !== 3'd1) begin
         errors++;
         $display("FAIL waw_pending got mask=%b count=%0d, expected 0010/1", pendingMask, ldCount);
      end
      checks++;
      if (aluReady !== 1'b0) begin
         errors++;
         $display("FAIL waw_blocked got aluReady=%b, expected 0", aluReady);
      end
      exp_q.push_back({2'd1, 32'h11});
      step();
      checks++;
      if (pendingMask !== 4'b0000 || aluReady !== 1'b1) begin
         errors++;
         $display("FAIL waw_release got mask=%b aluReady=%b, expected 0000/1", pendingMask, aluReady);
      end
      exp_q.push_back({2'd1, 32'h22});
      step();
      idle();
      step();
   endtask

   task automatic test_same_rd();
      aluValid = 1'b1;
      aluRd    = 2'd2;
      aluData  = 32'hA1;
      ldValid  = 1'b1;
      ldRd     = 2'd2;
      ldData   = 32'hB1;
      #1;
      checks++;
      if (aluReady !== 1'b1) begin
         errors++;
         $display("FAIL same_rd_alu_first got aluReady=%b, expected 1", aluReady);
      end
      exp_q.push_back({2'd2, 32'hA1});
      step();
      idle();
      #1;
      checks++;
      if (pendingMask !== 4'b0100) begin
         errors++;
         $display("FAIL same_rd_mask got %b, expected 0100", pendingMask);
      end
      exp_q.push_back({2'd2, 32'hB1});
      step();
      step();
   endtask

   task automatic test_starvation();
      logic [RS-1:0] alu_d;
      alu_d    = 32'h100;
      aluValid = 1'b1;
      aluRd    = 2'd0;
      for (int i = 0; i < 6; i++) begin
         aluData = alu_d;
         ldValid = (i == 0);
         ldRd    = 2'd2;
         ldData  = 32'h55;
         #1;
         checks++;
         if (aluReady !== (i != 4)) begin
            errors++;
            $display("FAIL starve_cycle%0d got aluReady=%b, expected %b", i, aluReady, (i != 4));
         end
         if (i == 4) begin
            exp_q.push_back({2'd2, 32'h55});
         end else begin
            exp_q.push_back({2'd0, alu_d});
            alu_d = alu_d + 1;
         end
         step();
      end
      idle();
      step();
   endtask

   task automatic test_full();
      logic [RS-1:0] alu_d;
      alu_d    = 32'h300;
      aluValid = 1'b1;
      aluRd    = 2'd0;
      for (int i = 0; i < 6; i++) begin
         aluData = alu_d;
         ldValid = (i < 5);
         ldRd    = (i < 4) ? SB'((i % 3) + 1) : 2'd2;
         ldData  = (i < 4) ? RS'(32'h41 + i) : 32'hBAD;
         #1;
         if (i == 4) begin
            checks++;
            if (ldReady !== 1'b0 || ldCount !== 3'd4 || aluReady !== 1'b0) begin
               errors++;
               $display("FAIL full_state got ldReady=%b count=%0d aluReady=%b, expected 0/4/0", ldReady, ldCount, aluReady);
            end
            checks++;
            if (pendingMask !== 4'b1110) begin
               errors++;
               $display("FAIL full_mask got %b, expected 1110", pendingMask);
            end
            exp_q.push_back({2'd1, 32'h41});
         end else begin
            checks++;
            if (ldReady !== 1'b1 || aluReady !== 1'b1) begin
               errors++;
               $display("FAIL full_fill%0d got ldReady=%b aluReady=%b, expected 1/1", i, ldReady, aluReady);
            end
            exp_q.push_back({2'd0, alu_d});
            alu_d = alu_d + 1;
         end
         if (i == 5) begin
            checks++;
            if (ldCount !== 3'd3 || pendingMask !== 4'b1110) begin
               errors++;
               $display("FAIL full_after_pop got count=%0d mask=%b, expected 3/1110", ldCount, pendingMask);
            end
         end
         step();
      end
      idle();
      for (int j = 1; j < 4; j++) begin
         exp_q.push_back({SB'((j % 3) + 1), RS'(32'h41 + j)});
         step();
      end
      checks++;
      if (ldCount !== '0 || pendingMask !== '0) begin
         errors++;
         $display("FAIL full_drain got count=%0d mask=%b, expected 0/0000", ldCount, pendingMask);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         ldValid = 1'b1;
         ldRd    = SB'($urandom_range(0, RQ - 1));
         ldData  = $urandom;
         #1;
         checks++;
         if (ldReady !== 1'b1 || ldCount !== ((i == 0) ? 3'd0 : 3'd1)) begin
            errors++;
            $display("FAIL b2b_load%0d got ldReady=%b count=%0d", i, ldReady, ldCount);
         end
         exp_q.push_back({ldRd, ldData});
         step();
      end
      idle();
      step();
      step();
      checks++;
      if (pendingMask !== '0 || ldCount !== '0) begin
         errors++;
         $display("FAIL b2b_drain got mask=%b count=%0d, expected 0/0", pendingMask, ldCount);
      end
   endtask

   task automatic test_reset_mid();
      aluValid = 1'b1;
      aluRd    = 2'd0;
      for (int i = 0; i < 3; i++) begin
         aluData = RS'(32'h500 + i);
         ldValid = 1'b1;
         ldRd    = SB'(i + 1);
         ldData  = RS'(32'hC1 + i);
         exp_q.push_back({2'd0, RS'(32'h500 + i)});
         step();
      end
      idle();
      checks++;
      if (ldCount !== 3'd3) begin
         errors++;
         $display("FAIL mid_queued got count=%0d, expected 3", ldCount);
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      #1;
      checks++;
      if (ldCount !== '0 || pendingMask !== '0 || regWrEn !== 1'b0 || ldReady !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got count=%0d mask=%b en=%b ldReady=%b, expected 0/0000/0/1",
                  ldCount, pendingMask, regWrEn, ldReady);
      end
      for (int i = 0; i < 6; i++) begin
         step();
      end
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_waw();
      test_same_rd();
      test_starvation();
      test_full();
      test_back_to_back();
      test_reset_mid();
      step();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes got %0d still queued, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
